// File: rtl/lsu_ctrl.sv
// lsu_ctrl: one-at-a-time load/store unit bridging the MEM stage to a req/ack data bus.
// Build option `LSU_SPLIT_EN: word-crossing misaligned accesses run as two bus beats.
module lsu_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                req_ready,
  output logic                stall,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_exc,
  output logic [1:0]          rsp_exc_code,
  output logic [ADDR_W-1:0]   exc_addr,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          fsm_state
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_BUS2 = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // the bus beat completes on a rising edge where mem_req && mem_ack.
  logic [1:0]        state;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [OFF_W-1:0]  off_q;

  logic [3:0]        nbytes;
  logic [OFF_W-1:0]  req_off;
  logic              illegal;
  logic [DATA_W-1:0] rep_wdata;
  logic [DATA_W-1:0] place_wdata;
  logic [DATA_W-1:0] load_raw;
  logic [DATA_W-1:0] load_ext;
  logic              msb;
  int                ext_bits;

`ifdef LSU_SPLIT_EN
  logic [2*NB-1:0]   wide_be;
  logic [NB-1:0]     be_hi_q;
  logic [DATA_W-1:0] beat0_q;
  logic              split_q;
  logic [2*DATA_W-1:0] wide_rd;
`else
  logic              misaligned;
  logic [NB-1:0]     req_be;
`endif

  assign req_ready = (state == S_IDLE);
  assign stall     = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign mem_req   = (state == S_BUS) || (state == S_BUS2);
  assign fsm_state = state;

  always_comb begin
    nbytes  = 4'd1 << req_size;
    req_off = req_addr[OFF_W-1:0];
    illegal = (DATA_W == 32) && (req_size == 2'd3);
    case (req_size)
      2'd0:    rep_wdata = {NB{req_wdata[7:0]}};
      2'd1:    rep_wdata = {(NB/2){req_wdata[15:0]}};
      2'd2:    rep_wdata = {(NB/4){req_wdata[31:0]}};
      default: rep_wdata = req_wdata;
    endcase
`ifdef LSU_SPLIT_EN
    wide_be = '0;
    for (int i = 0; i < NB; i++) wide_be[i] = (i < int'(nbytes));
    wide_be = wide_be << req_off;
    // Rotating the replicated pattern puts field byte 0 in the start lane for any offset.
    place_wdata = (rep_wdata << {req_off, 3'b000}) |
                  (rep_wdata >> (DATA_W - 8 * int'(req_off)));
`else
    misaligned = (req_addr[2:0] & (nbytes[2:0] - 3'd1)) != 3'd0;
    req_be = '0;
    for (int i = 0; i < NB; i++) req_be[i] = (i < int'(nbytes));
    req_be = req_be << req_off;
    place_wdata = rep_wdata;
`endif
  end

  always_comb begin
`ifdef LSU_SPLIT_EN
    wide_rd  = split_q ? {mem_rdata, beat0_q} : {{DATA_W{1'b0}}, mem_rdata};
    load_raw = DATA_W'(wide_rd >> {off_q, 3'b000});
`else
    load_raw = mem_rdata >> {off_q, 3'b000};
`endif
    ext_bits = 8 << size_q;
    if (ext_bits > DATA_W) ext_bits = DATA_W;
    case (size_q)
      2'd0:    msb = load_raw[7];
      2'd1:    msb = load_raw[15];
      2'd2:    msb = load_raw[31];
      default: msb = load_raw[DATA_W-1];
    endcase
    load_ext = load_raw;
    for (int i = 0; i < DATA_W; i++)
      if (i >= ext_bits) load_ext[i] = uns_q ? 1'b0 : msb;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      size_q       <= '0;
      uns_q        <= 1'b0;
      off_q        <= '0;
      rsp_data     <= '0;
      rsp_exc      <= 1'b0;
      rsp_exc_code <= 2'b00;
      exc_addr     <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
`ifdef LSU_SPLIT_EN
      be_hi_q      <= '0;
      beat0_q      <= '0;
      split_q      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          size_q       <= req_size;
          uns_q        <= req_unsigned;
          off_q        <= req_off;
          rsp_data     <= '0;
          rsp_exc      <= 1'b0;
          rsp_exc_code <= 2'b00;
          if (illegal) begin
            state        <= S_RESP;
            rsp_exc      <= 1'b1;
            rsp_exc_code <= 2'b10;
            exc_addr     <= req_addr;
`ifndef LSU_SPLIT_EN
          end else if (misaligned) begin
            state        <= S_RESP;
            rsp_exc      <= 1'b1;
            rsp_exc_code <= 2'b01;
            exc_addr     <= req_addr;
`endif
          end else begin
            state     <= S_BUS;
            mem_we    <= req_write;
            mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_wdata <= place_wdata;
`ifdef LSU_SPLIT_EN
            mem_be    <= wide_be[NB-1:0];
            be_hi_q   <= wide_be[2*NB-1:NB];
            split_q   <= |wide_be[2*NB-1:NB];
`else
            mem_be    <= req_be;
`endif
          end
        end
        S_BUS: if (mem_ack) begin
`ifdef LSU_SPLIT_EN
          if (split_q) begin
            state    <= S_BUS2;
            beat0_q  <= mem_rdata;
            mem_addr <= mem_addr + ADDR_W'(NB);
            mem_be   <= be_hi_q;
          end else begin
            state    <= S_RESP;
            rsp_data <= mem_we ? '0 : load_ext;
          end
`else
          state    <= S_RESP;
          rsp_data <= mem_we ? '0 : load_ext;
`endif
        end
`ifdef LSU_SPLIT_EN
        S_BUS2: if (mem_ack) begin
          state    <= S_RESP;
          rsp_data <= mem_we ? '0 : load_ext;
        end
`endif
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Parametrised load/store unit sitting between the MEM pipeline stage and the data-memory/MMIO bus. Accepts one byte/half/word/dword access at a time, drives a request/acknowledge bus with arbitrary wait states, extracts and sign- or zero-extends load data, builds byte enables and replicated store data, and raises alignment or size exceptions. Stalls the pipeline while an access is outstanding.

## Interface
- DATA_W, 32: bus and register width; 32 or 64.
- ADDR_W, 32: byte-address width.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low.
- req_valid  in  1  MEM stage presents an access.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword.
- req_unsigned  in  1  zero-extend load (lbu/lhu/lwu).
- req_write  in  1  1 store, 0 load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- req_ready  out  1  high only in IDLE.
- stall  out  1  high whenever state is not IDLE.
- rsp_valid  out  1  one-cycle pulse, access complete.
- rsp_data  out  DATA_W  extended load data; 0 for stores and exceptions.
- rsp_exc  out  1  exception flag, valid with rsp_valid.
- rsp_exc_code  out  2  01 misaligned, 10 illegal size.
- exc_addr  out  ADDR_W  faulting req_addr.
- mem_req  out  1  bus request, held until mem_ack.
- mem_we  out  1  bus write.
- mem_addr  out  ADDR_W  address aligned to DATA_W/8.
- mem_be  out  DATA_W/8  byte enables, bit i = byte lane i.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_ack  in  1  bus completes the beat this cycle.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.

## Operation
- Little-endian: byte at offset k occupies bits [8k+7:8k].
- States: IDLE, BUS, BUS2 (LSU_SPLIT_EN only), RESP.
- IDLE: on req_valid, latch request. Illegal size (size 3 with DATA_W=32) -> RESP with code 10. Misaligned (addr mod size != 0) -> RESP with code 01, no bus access. Otherwise -> BUS.
- BUS: mem_req=1; on mem_ack capture lanes -> RESP (or BUS2 for split).
- RESP: rsp_valid=1 for one cycle -> IDLE.
- Load extension: select size bytes at offset addr[log2(DATA_W/8)-1:0]; sign-extend from MSB of field unless req_unsigned; word load on DATA_W=32 passes through unchanged.
- Store: mem_be = size-wide mask shifted to offset; mem_wdata = low size bytes replicated across all lanes.
- Reset values: state IDLE, req_ready 1, stall 0, rsp_valid 0, rsp_exc 0, rsp_exc_code 0, rsp_data 0, exc_addr 0, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0.
- Reset low in any state: next edge IDLE, mem_req 0; a late mem_ack is ignored.
- mem_ack while not in BUS/BUS2 is ignored.

## Timing
- Request accepted edge = cycle 0; mem_req high from cycle 1.
- Zero-wait aligned access: mem_ack in cycle 1, rsp_valid in cycle 2.
- Each wait cycle (mem_ack low) adds one cycle; mem_addr/mem_be/mem_wdata/mem_we registered and stable while mem_req high.
- Exceptions: rsp_valid in cycle 1, mem_req never asserted.
- Next request accepted at earliest in the cycle after rsp_valid.

## Configuration
- LSU_SPLIT_EN defined: misaligned accesses never raise code 01. Accesses within one DATA_W word run as a single beat. Accesses crossing a word boundary run two beats: BUS at floor address (upper lanes), BUS2 at floor+DATA_W/8 (lower lanes), data merged then extended; store enables split likewise. Split zero-wait latency: rsp_valid in cycle 3.
- Undefined: BUS2 absent; any misaligned access raises code 01.

## Test plan
- DATA_W=32, lb at 0x1003, mem_rdata 0x80FF1234 -> mem_addr 0x1000, rsp_data 0xFFFFFF80; lbu same -> 0x00000080.
- lhu at 0x1002, mem_rdata 0xBEEF0000 -> rsp_data 0x0000BEEF; sh at 0x1002, wdata 0x0000ABCD -> mem_be 4'b1100, mem_wdata 0xABCDABCD, mem_we 1.
- Macro off: lw at 0x1001 -> no mem_req, rsp_valid cycle 1, rsp_exc 1, code 01, exc_addr 0x1001; size 3 -> code 10.
- Macro on: lw at 0x1001, beats at 0x1000 (rdata 0x44332211, be 4'b1110) and 0x1004 (rdata 0x88776655, be 4'b0001) -> rsp_data 0x55443322, rsp_exc 0.
- mem_ack low 5 cycles -> mem_req and stall held high, stable address; rsp_valid exactly one cycle after ack.
- Reset low during BUS -> next cycle mem_req 0, req_ready 1; subsequent mem_ack produces no rsp_valid.
